// File: rtl/blob_labeler.sv
// Streaming binary-image connected-component counter: one-pass labelling,
// then resolve/merge/max/count sweeps over the label tables.
// Ports: i_clk, i_rst (async high), i_valid/i_seq/i_last pixel stream;
// o_busy, o_valid, o_count, o_max_area, o_overflow results.
// Option: define BLOB_CONN8_EN for 8-connectivity (default 4-connectivity).
module blob_labeler #(
  parameter int IMG_COL   = 640,
  parameter int IMG_ROW   = 480,
  parameter int LABEL_W   = 8,
  parameter int AREA_W    = 19,
  parameter int MIN_SHIFT = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_seq,
  input  logic               i_last,
  output logic               o_busy,
  output logic               o_valid,
  output logic [LABEL_W-1:0] o_count,
  output logic [AREA_W-1:0]  o_max_area,
  output logic               o_overflow
);

  localparam int CW = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int RW = $clog2(IMG_ROW + 1);
  localparam int NL = 1 << LABEL_W;
  localparam int NW = LABEL_W + 1;
`ifdef BLOB_CONN8_EN
  localparam int NB = 4;
`else
  localparam int NB = 2;
`endif

  typedef logic [LABEL_W-1:0] lbl_t;
  typedef logic [AREA_W-1:0]  area_t;

  localparam area_t          AMAX  = '1;
  localparam logic [CW-1:0]  CLAST = CW'(IMG_COL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_RESOLVE, S_MERGE,
    S_FINDMAX, S_COUNT, S_OUTPUT
  } state_t;

  state_t state_q, state_d;

  lbl_t  lb_q   [IMG_COL];
  lbl_t  par_q  [NL];
  area_t area_q [NL];

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  lbl_t          left_q;
  logic [NW-1:0] nxt_q;
  logic [NW-1:0] k_q, k_d;
  area_t         mx_q;
  lbl_t          cnt_q;
  logic          ovf_q;
  lbl_t          oc_q;
  area_t         om_q;
  logic          oo_q;

  logic          pix_en, top, c0;
  logic [CW-1:0] col_nx;
  lbl_t          nb [NB];
  logic          any, full;
  lbl_t          rmin, rmax, rt, lbl, nl;
  area_t         ainc;

`ifdef BLOB_CONN8_EN
  // Up-left is the previous pixel's up read: that slot is already
  // overwritten with the current row by the time we need it.
  lbl_t ul_q;
  logic cl;
  assign cl = (col_q == CLAST);
`endif

  assign pix_en = i_valid &&
                  (state_q == S_IDLE || state_q == S_SCAN);
  assign top    = (row_q != '0);
  assign c0     = (col_q == '0);
  assign col_nx = (col_q == CLAST) ? '0 : col_q + 1'b1;
  assign full   = (nxt_q == NW'(NL));
  assign nl     = nxt_q[LABEL_W-1:0];

  always_comb begin
    nb[0] = c0 ? '0 : left_q;
    nb[1] = top ? lb_q[col_q] : '0;
`ifdef BLOB_CONN8_EN
    nb[2] = (top && !c0) ? ul_q : '0;
    nb[3] = (top && !cl) ? lb_q[col_nx] : '0;
`endif
  end

  always_comb begin
    any  = 1'b0;
    rmin = '1;
    rmax = '0;
    rt   = '0;
    for (int i = 0; i < NB; i++) begin
      if (nb[i] != '0) begin
        any = 1'b1;
        rt  = par_q[nb[i]];
        if (rt < rmin) rmin = rt;
        if (rt > rmax) rmax = rt;
      end
    end
  end

  always_comb begin
    lbl = '0;
    if (i_seq) begin
      if (any)       lbl = rmin;
      else if (!full) lbl = nl;
    end
  end

  assign ainc = (area_q[rmin] == AMAX) ?
                AMAX : area_q[rmin] + 1'b1;

  lbl_t            kl, pk;
  area_t           ak, ap, msat, thr;
  logic [AREA_W:0] msum;
  logic            kin, asc_last, desc_last, hit;

  assign kl   = k_q[LABEL_W-1:0];
  assign kin  = (k_q != '0) && (k_q < nxt_q);
  assign pk   = par_q[kl];
  assign ak   = area_q[kl];
  assign ap   = area_q[pk];
  assign msum = {1'b0, ap} + {1'b0, ak};
  assign msat = msum[AREA_W] ? AMAX : msum[AREA_W-1:0];
  assign thr  = mx_q >> MIN_SHIFT;
  assign hit  = kin && (ak != '0) && (ak > thr);

  assign asc_last  = (k_q + NW'(1)) >= nxt_q;
  assign desc_last = (k_q <= NW'(1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: if (i_valid) begin
        state_d = i_last ? S_RESOLVE : S_SCAN;
        k_d     = NW'(1);
      end
      S_SCAN: if (i_valid && i_last) begin
        state_d = S_RESOLVE;
        k_d     = NW'(1);
      end
      S_RESOLVE: if (asc_last) begin
        state_d = S_MERGE;
        k_d     = nxt_q - NW'(1);
      end else k_d = k_q + NW'(1);
      S_MERGE: if (desc_last) begin
        state_d = S_FINDMAX;
        k_d     = NW'(1);
      end else k_d = k_q - NW'(1);
      S_FINDMAX: if (asc_last) begin
        state_d = S_COUNT;
        k_d     = NW'(1);
      end else k_d = k_q + NW'(1);
      S_COUNT: if (asc_last) state_d = S_OUTPUT;
               else k_d = k_q + NW'(1);
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign o_busy     = !(state_q == S_IDLE || state_q == S_SCAN);
  assign o_valid    = (state_q == S_OUTPUT);
  assign o_count    = oc_q;
  assign o_max_area = om_q;
  assign o_overflow = oo_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      left_q  <= '0;
      nxt_q   <= NW'(1);
      mx_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      oc_q    <= '0;
      om_q    <= '0;
      oo_q    <= 1'b0;
`ifdef BLOB_CONN8_EN
      ul_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (pix_en) begin
        left_q <= lbl;
`ifdef BLOB_CONN8_EN
        ul_q   <= lb_q[col_q];
`endif
        col_q  <= col_nx;
        if (col_q == CLAST) row_q <= row_q + 1'b1;
        if (i_seq && !any) begin
          if (full) ovf_q <= 1'b1;
          else      nxt_q <= nxt_q + NW'(1);
        end
      end
      if (state_q == S_MERGE)   mx_q  <= '0;
      if (state_q == S_FINDMAX) begin
        cnt_q <= '0;
        if (kin && ak > mx_q) mx_q <= ak;
      end
      if (state_q == S_COUNT) begin
        if (hit) cnt_q <= cnt_q + 1'b1;
        if (asc_last) begin
          oc_q <= cnt_q + (hit ? lbl_t'(1) : lbl_t'(0));
          om_q <= mx_q;
          oo_q <= ovf_q;
        end
      end
      if (state_q == S_OUTPUT) begin
        nxt_q  <= NW'(1);
        ovf_q  <= 1'b0;
        col_q  <= '0;
        row_q  <= '0;
        left_q <= '0;
      end
    end
  end

  // Tables are never cleared: entries at or above nxt_q are never read.
  always_ff @(posedge i_clk) begin
    if (pix_en) begin
      lb_q[col_q] <= lbl;
      if (i_seq) begin
        if (any) begin
          area_q[rmin] <= ainc;
          if (rmax != rmin) par_q[rmax] <= rmin;
        end else if (!full) begin
          par_q[nl]  <= nl;
          area_q[nl] <= AREA_W'(1);
        end
      end
    end
    if (state_q == S_RESOLVE && kin)
      par_q[kl] <= par_q[pk];
    if (state_q == S_MERGE && kin && pk != kl) begin
      area_q[pk] <= msat;
      area_q[kl] <= '0;
    end
  end

endmodule

// File: tb/tb_blob_labeler.sv
// Self-checking bench for blob_labeler: table of 8x4 frames through a
// LABEL_W=4 instance, plus overflow/reset sequences on a LABEL_W=2 one.
module tb_blob_labeler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, vld, seq, last, sel1;
  logic v0, v1;
  assign v0 = vld && !sel1;
  assign v1 = vld && sel1;

  logic        busy0, ov0, ovf0;
  logic [3:0]  cnt0;
  logic [18:0] max0;
  logic        busy1, ov1, ovf1;
  logic [1:0]  cnt1;
  logic [18:0] max1;

  blob_labeler #(.IMG_COL(8), .IMG_ROW(4), .LABEL_W(4),
                 .AREA_W(19), .MIN_SHIFT(3)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_valid(v0), .i_seq(seq),
    .i_last(last), .o_busy(busy0), .o_valid(ov0),
    .o_count(cnt0), .o_max_area(max0), .o_overflow(ovf0));

  blob_labeler #(.IMG_COL(8), .IMG_ROW(4), .LABEL_W(2),
                 .AREA_W(19), .MIN_SHIFT(3)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_valid(v1), .i_seq(seq),
    .i_last(last), .o_busy(busy1), .o_valid(ov1),
    .o_count(cnt1), .o_max_area(max1), .o_overflow(ovf1));

  typedef struct {
    logic [31:0] img;
    int          cnt;
    int          mx;
    int          ovf;
    string       nm;
  } vec_t;

  typedef struct {
    int    cnt;
    int    mx;
    int    ovf;
    string nm;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_res(input bit s, input bit junk);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (junk && c == 0) chk("busy_after_last", s ? busy1 : busy0, 1);
      if (s ? ov1 : ov0) begin
        got = 1'b1;
        vld = 1'b0;
      end else begin
        vld  = junk;
        seq  = 1'b1;
        last = c[0];
      end
    end
    vld = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      n_total++;
      $display("FAIL %s timeout: no o_valid in 300 cycles", e.nm);
    end else if (s) begin
      chk({e.nm, "_count"}, int'(cnt1), e.cnt);
      chk({e.nm, "_max"}, int'(max1), e.mx);
      chk({e.nm, "_ovf"}, int'(ovf1), e.ovf);
    end else begin
      chk({e.nm, "_count"}, int'(cnt0), e.cnt);
      chk({e.nm, "_max"}, int'(max0), e.mx);
      chk({e.nm, "_ovf"}, int'(ovf0), e.ovf);
    end
  endtask

  task automatic send_frame(input bit s, input logic [31:0] img,
                            input int c, input int m, input int o,
                            input string nm, input bit junk);
    sb.push_back('{cnt: c, mx: m, ovf: o, nm: nm});
    sel1 = s;
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      vld  = 1'b1;
      seq  = img[31-p];
      last = (p == 31);
    end
    wait_res(s, junk);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    vld = 1'b0; seq = 1'b0; last = 1'b0; sel1 = 1'b0;

    vecs[0] = '{32'h0, 0, 0, 0, "zero"};
    vecs[1] = '{{8'b11000110, 8'b11000110, 16'h0}, 2, 4, 0, "squares"};
    vecs[2] = '{{8'b10001000, 8'b10001000, 8'b11111000, 8'h0},
                1, 9, 0, "u_shape"};
`ifdef BLOB_CONN8_EN
    vecs[3] = '{{8'b10000000, 8'b01000000, 16'h0}, 1, 2, 0, "diag"};
    vecs[6] = '{{4{8'b10101010}} ^ {8'h00, 8'hff, 8'h00, 8'hff},
                1, 16, 0, "checker"};
`else
    vecs[3] = '{{8'b10000000, 8'b01000000, 16'h0}, 2, 1, 0, "diag"};
    vecs[6] = '{{4{8'b10101010}} ^ {8'h00, 8'hff, 8'h00, 8'hff},
                15, 1, 1, "checker"};
`endif
    vecs[4] = '{{8'b11110001, {3{8'b11110000}}}, 1, 16, 0, "block"};
    vecs[5] = '{32'hffff_ffff, 1, 32, 0, "full"};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_max", max0, 0);
    chk("rst_ovf", ovf0, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      send_frame(1'b0, vecs[i].img, vecs[i].cnt, vecs[i].mx,
                 vecs[i].ovf, vecs[i].nm, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("hold_valid", ov0, 0);
    chk("hold_count", cnt0, vecs[6].cnt);
    chk("hold_max", max0, vecs[6].mx);

    send_frame(1'b0, vecs[2].img, 1, 9, 0, "u_busy_junk", 1'b1);

    send_frame(1'b1, {8'b10101010, 8'h0, 8'b10000000, 8'h0},
               3, 1, 1, "ovf5", 1'b0);

    sel1 = 1'b1;
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      vld = 1'b1; seq = 1'b1; last = 1'b0;
    end
    @(negedge clk);
    rst1 = 1'b1;
    vld  = 1'b0;
    @(negedge clk);
    chk("midrst_ovf", ovf1, 0);
    chk("midrst_count", cnt1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_valid", ov1, 0);
    rst1 = 1'b0;
    @(negedge clk);
    send_frame(1'b1, {8'b11000000, 8'b11000000, 16'h0},
               1, 4, 0, "clean_after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blob_labeler.md
BLOB_LABELER -- requirements
Module: blob_labeler

Interface
REQ-001 SHALL provide parameter IMG_COL, default 640, pixels per row.
REQ-002 SHALL provide parameter IMG_ROW, default 480, rows per frame (informational; frame end is signalled by i_last).
REQ-003 SHALL provide parameter LABEL_W, default 8, label width; labels 1..2^LABEL_W-1 are usable and 0 means background.
REQ-004 SHALL provide parameter AREA_W, default 19, per-label area counter width.
REQ-005 SHALL provide parameter MIN_SHIFT, default 3; a blob counts when area > (max_area >> MIN_SHIFT).
REQ-006 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port i_valid  input  1  pixel strobe, one pixel per asserted cycle, raster order.
REQ-009 SHALL have port i_seq  input  1  binary pixel value; 1 is foreground.
REQ-010 SHALL have port i_last  input  1  qualified by i_valid; marks the final pixel of the frame.
REQ-011 SHALL have port o_busy  output  1  high whenever the block is resolving; pixels presented then are ignored.
REQ-012 SHALL have port o_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have port o_count  output  LABEL_W  number of qualifying blobs.
REQ-014 SHALL have port o_max_area  output  AREA_W  largest merged blob area.
REQ-015 SHALL have port o_overflow  output  1  label space was exhausted this frame.

Function
REQ-016 SHALL implement states IDLE, SCAN, RESOLVE, MERGE, FINDMAX, COUNT and OUTPUT.
REQ-017 Transitions SHALL be:
- IDLE to SCAN on the first i_valid, and that pixel is processed.
- SCAN to RESOLVE on i_valid&&i_last.
- Each sweep state proceeds to the next sweep state; COUNT goes to OUTPUT, and OUTPUT returns to IDLE.
REQ-018 SHALL keep column and row counters; the column wraps IMG_COL-1 to 0 and increments the row; both clear on entering SCAN.
REQ-019 SHALL hold the previous row's labels in an IMG_COL-entry line buffer of LABEL_W bits.
REQ-020 Neighbour rules: in row 0 all up-neighbours read 0; in column 0 left/up-left read 0; in column IMG_COL-1 up-right reads 0.
REQ-021 Pixel labelling:
- Background gets label 0.
- Foreground with all neighbours 0 gets a new label n (next_lbl); set parent[n]=n, area[n]=1, increment next_lbl.
- Otherwise take r=min of parent[] of the nonzero neighbours and increment area[r].
REQ-022 When two nonzero neighbour roots ra≠rb, the block SHALL write parent[max(ra,rb)]=min(ra,rb) in the same cycle.
REQ-023 If no label is free, the foreground pixel SHALL be labelled 0, not counted, and o_overflow set; the frame still completes.
REQ-024 Area arithmetic SHALL saturate at 2^AREA_W-1 everywhere.
REQ-025 RESOLVE SHALL, for k ascending 1..n-1 (n = labels allocated), set parent[k]=parent[parent[k]].
REQ-026 MERGE SHALL, for k descending n-1..1 with parent[k]≠k, add area[k] into area[parent[k]] and clear area[k].
REQ-027 FINDMAX SHALL, over k=1..n-1, record the maximum area into o_max_area.
REQ-028 COUNT SHALL, over k=1..n-1, count entries with area≠0 and area > (max >> MIN_SHIFT).
REQ-029 Each sweep state SHALL take max(n-1,1) cycles; o_valid SHALL be high for exactly the OUTPUT cycle.
REQ-030 o_count, o_max_area and o_overflow SHALL hold until the next frame's OUTPUT.
REQ-031 o_busy SHALL be high in RESOLVE through OUTPUT; i_valid in those states SHALL be ignored.
REQ-032 Stale table entries at or above next_lbl SHALL never be read; no explicit table clear is needed.

Reset
REQ-033 On i_rst: state returns to IDLE; next_lbl=1; counters=0; o_busy=0, o_valid=0, o_count=0, o_max_area=0, o_overflow=0.
REQ-034 Reset mid-frame SHALL abandon the frame; the next frame SHALL produce results unaffected by it.

Configuration
REQ-035 Macro BLOB_CONN8_EN: when defined, neighbours are left, up-left, up and up-right (8-connectivity); when undefined, neighbours are left and up only (4-connectivity, no diagonal reads).

Verification (IMG_COL=8, LABEL_W=4, MIN_SHIFT=3 unless stated)
REQ-036 All-zero 8x4 frame -> o_valid pulse; o_count=0, o_max_area=0, o_overflow=0.
REQ-037 Two disjoint 2x2 squares -> o_count=2, o_max_area=4.
REQ-038 U shape (rows 10001000,10001000,11111000) -> labels merge; o_count=1, o_max_area=9.
REQ-039 Pixels at (0,0) and (1,1) only -> with BLOB_CONN8_EN: o_count=1, o_max_area=2; without: o_count=2, o_max_area=1.
REQ-040 A 16-pixel block plus one isolated pixel -> threshold 2, so o_count=1, o_max_area=16.
REQ-041 LABEL_W=2 with five isolated pixels -> o_overflow=1, o_count=3; then i_rst mid-SCAN and a clean frame -> o_overflow=0 and a correct count.
